// File: rtl/write_back.sv
// Final pipeline stage: registers the commit onto the register-file write port and
// tracks pending writes per register for hazard detection and same-cycle bypass.
module write_back #(
  parameter int DATA_W       = 64,
  parameter int REG_ADDR_W   = 4,
  parameter int CTRL_W       = 8,
  parameter int WE_BIT       = 6,
  parameter int MEM2REG_BIT  = 1,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [CTRL_W-1:0]     mem_control_rod,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_load_data,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] query_addr1,
  input  logic [REG_ADDR_W-1:0] query_addr2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  fwd_valid1,
  output logic                  fwd_valid2,
  output logic [DATA_W-1:0]     fwd_data1,
  output logic [DATA_W-1:0]     fwd_data2,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_port_address,
  output logic [DATA_W-1:0]     write_data,
  output logic [15:0]           retire_count,
  output logic                  sb_underflow
);

  localparam int NREG  = 2 ** REG_ADDR_W;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_r [NREG];
  logic              commit_s;
  logic [DATA_W-1:0] wdata_s;
  logic [NREG-1:0]   inc_s;
  logic [NREG-1:0]   dec_s;
  logic              uflow_s;
  logic              unused_rod_s;

  // Commit decode and result selection from the memory stage
  always_comb begin
    commit_s     = mem_valid & mem_control_rod[WE_BIT];
    wdata_s      = mem_control_rod[MEM2REG_BIT] ? mem_load_data : mem_alu_result;
    unused_rod_s = ^mem_control_rod;
  end

  // Issue back-pressure, source-register hazard and bypass queries
  always_comb begin
    issue_ready = (cnt_r[issue_dest] != CNT_MAX) |
                  (write_enable & (write_port_address == issue_dest));
    fwd_valid1  = write_enable & (query_addr1 == write_port_address);
    fwd_valid2  = write_enable & (query_addr2 == write_port_address);
    fwd_data1   = write_data;
    fwd_data2   = write_data;
    hazard1     = cnt_r[query_addr1] > (fwd_valid1 ? CNT_ONE : CNT_ZERO);
    hazard2     = cnt_r[query_addr2] > (fwd_valid2 ? CNT_ONE : CNT_ZERO);
  end

  // Per-register increment/decrement requests; a retire hitting an empty counter is an underflow
  always_comb begin
    uflow_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      inc_s[i] = issue_valid & issue_ready & (issue_dest == REG_ADDR_W'(i));
      dec_s[i] = write_enable & (write_port_address == REG_ADDR_W'(i));
      if (dec_s[i] && !inc_s[i] && (cnt_r[i] == CNT_ZERO)) begin
        uflow_s = 1'b1;
      end else begin
        uflow_s = uflow_s;
      end
    end
  end

  // Write-port registers, retire counter and sticky underflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable       <= 1'b0;
      write_port_address <= '0;
      write_data         <= '0;
      retire_count       <= 16'd0;
      sb_underflow       <= 1'b0;
    end else begin
      write_enable <= commit_s;
      if (commit_s) begin
        write_port_address <= mem_dest;
        write_data         <= wdata_s;
        retire_count       <= retire_count + 16'd1;
      end
      if (uflow_s) begin
        sb_underflow <= 1'b1;
      end
    end
  end

  // Pending-write counters; simultaneous issue and retire of one register cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
          2'b01:   cnt_r[i] <= (cnt_r[i] == CNT_ZERO) ? CNT_ZERO : cnt_r[i] - CNT_ONE;
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Directed and randomized bench for write_back against a per-register pending-count model.
module tb_write_back;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [7:0]  mem_control_rod;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_load_data;
  logic [3:0]  mem_dest;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic        issue_ready;
  logic [3:0]  query_addr1;
  logic [3:0]  query_addr2;
  logic        hazard1;
  logic        hazard2;
  logic        fwd_valid1;
  logic        fwd_valid2;
  logic [63:0] fwd_data1;
  logic [63:0] fwd_data2;
  logic        write_enable;
  logic [3:0]  write_port_address;
  logic [63:0] write_data;
  logic [15:0] retire_count;
  logic        sb_underflow;

  always #5 clk = ~clk;

  write_back dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_control_rod(mem_control_rod),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data), .mem_dest(mem_dest),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .query_addr1(query_addr1), .query_addr2(query_addr2), .hazard1(hazard1), .hazard2(hazard2),
    .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .write_enable(write_enable), .write_port_address(write_port_address), .write_data(write_data),
    .retire_count(retire_count), .sb_underflow(sb_underflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a pending-write count per register plus the one staged write
  int          pend [16];
  bit          m_we;
  logic [3:0]  m_addr;
  logic [63:0] m_data;
  int          m_ret;
  bit          m_uf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pend[i] = 0;
    m_we = 0; m_addr = 4'd0; m_data = 64'd0; m_ret = 0; m_uf = 0;
  endtask

  function automatic bit m_ready();
    return (pend[issue_dest] != 3) || (m_we && m_addr == issue_dest);
  endfunction

  task automatic check_outputs();
    bit f1, f2;
    f1 = m_we && (query_addr1 == m_addr);
    f2 = m_we && (query_addr2 == m_addr);
    chk("write_enable", {63'd0, write_enable}, {63'd0, m_we});
    chk("write_addr", {60'd0, write_port_address}, {60'd0, m_addr});
    chk("write_data", write_data, m_data);
    chk("retire_count", {48'd0, retire_count}, 64'(m_ret % 65536));
    chk("sb_underflow", {63'd0, sb_underflow}, {63'd0, m_uf});
    chk("issue_ready", {63'd0, issue_ready}, {63'd0, m_ready()});
    chk("fwd_valid1", {63'd0, fwd_valid1}, {63'd0, f1});
    chk("fwd_valid2", {63'd0, fwd_valid2}, {63'd0, f2});
    chk("fwd_data1", fwd_data1, m_data);
    chk("fwd_data2", fwd_data2, m_data);
    chk("hazard1", {63'd0, hazard1}, {63'd0, pend[query_addr1] > (f1 ? 1 : 0)});
    chk("hazard2", {63'd0, hazard2}, {63'd0, pend[query_addr2] > (f2 ? 1 : 0)});
  endtask

  task automatic model_edge();
    int dec, inc;
    if (reset) begin
      model_reset();
    end else begin
      dec = m_we ? int'(m_addr) : -1;
      inc = (issue_valid && m_ready()) ? int'(issue_dest) : -1;
      if (dec >= 0 && dec != inc) begin
        if (pend[dec] == 0) m_uf = 1;
        else pend[dec]--;
      end
      if (inc >= 0 && inc != dec) pend[inc]++;
      m_we = mem_valid && mem_control_rod[6];
      if (m_we) begin
        m_addr = mem_dest;
        m_data = mem_control_rod[1] ? mem_load_data : mem_alu_result;
        m_ret++;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; mem_valid = 1'b0; mem_control_rod = 8'h00; mem_alu_result = 64'd0;
    mem_load_data = 64'd0; mem_dest = 4'd0; issue_valid = 1'b0; issue_dest = 4'd0;
    query_addr1 = 4'd0; query_addr2 = 4'd0;
  endtask

  task automatic commit(input logic [7:0] rod, input logic [3:0] dest,
                        input logic [63:0] alu, input logic [63:0] ld);
    mem_valid = 1'b1; mem_control_rod = rod; mem_dest = dest;
    mem_alu_result = alu; mem_load_data = ld;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    idle();
    cycle();

    // ALU write, then a load-select write, then a rod without the write-enable bit
    commit(8'h40, 4'd5, 64'h1234, 64'h9999);
    cycle();
    idle();
    #1;
    chk("t1_we", {63'd0, write_enable}, 64'd1);
    chk("t1_addr", {60'd0, write_port_address}, 64'd5);
    chk("t1_data", write_data, 64'h1234);
    chk("t1_count", {48'd0, retire_count}, 64'd1);
    cycle();
    chk("t1_we_off", {63'd0, write_enable}, 64'd0);
    commit(8'h42, 4'd6, 64'h1, 64'hDEAD);
    cycle();
    idle();
    chk("t2_load", write_data, 64'hDEAD);
    commit(8'h02, 4'd8, 64'h5, 64'h6);
    cycle();
    idle();
    chk("t2_nowrite", {63'd0, write_enable}, 64'd0);
    cycle();

    // Hazard then bypass on r3
    issue_valid = 1'b1; issue_dest = 4'd3;
    cycle();
    idle();
    query_addr1 = 4'd3;
    #1;
    chk("t3_hazard", {63'd0, hazard1}, 64'd1);
    commit(8'h40, 4'd3, 64'h77, 64'h0);
    cycle();
    mem_valid = 1'b0;
    #1;
    chk("t3_bypass_hz", {63'd0, hazard1}, 64'd0);
    chk("t3_fwd_v", {63'd0, fwd_valid1}, 64'd1);
    chk("t3_fwd_d", fwd_data1, 64'h77);
    cycle();
    chk("t3_after_fv", {63'd0, fwd_valid1}, 64'd0);
    chk("t3_after_hz", {63'd0, hazard1}, 64'd0);

    // Saturate r7, then issue a fourth while r7 retires
    issue_valid = 1'b1; issue_dest = 4'd7; query_addr2 = 4'd7;
    repeat (3) cycle();
    #1;
    chk("t4_sat_ready", {63'd0, issue_ready}, 64'd0);
    issue_valid = 1'b0;
    commit(8'h40, 4'd7, 64'h7777, 64'h0);
    cycle();
    mem_valid = 1'b0; issue_valid = 1'b1;
    #1;
    chk("t4_ready_dec", {63'd0, issue_ready}, 64'd1);
    cycle();
    issue_valid = 1'b0;
    #1;
    chk("t4_still_sat", {63'd0, issue_ready}, 64'd0);
    chk("t4_hazard", {63'd0, hazard2}, 64'd1);
    cycle();

    // Retire to an empty register
    commit(8'h40, 4'd9, 64'h9, 64'h0);
    cycle();
    idle();
    repeat (2) cycle();
    chk("t5_uflow", {63'd0, sb_underflow}, 64'd1);
    query_addr1 = 4'd9;
    repeat (3) cycle();
    chk("t5_uflow_held", {63'd0, sb_underflow}, 64'd1);

    // Reset with pending counts and a staged write
    issue_valid = 1'b1; issue_dest = 4'd2; query_addr1 = 4'd2; query_addr2 = 4'd7;
    commit(8'h40, 4'd4, 64'hAB, 64'h0);
    cycle();
    idle();
    reset = 1'b1; query_addr1 = 4'd2; query_addr2 = 4'd7;
    cycle();
    reset = 1'b0;
    #1;
    chk("t6_we", {63'd0, write_enable}, 64'd0);
    chk("t6_hz1", {63'd0, hazard1}, 64'd0);
    chk("t6_hz2", {63'd0, hazard2}, 64'd0);
    chk("t6_count", {48'd0, retire_count}, 64'd0);
    chk("t6_uflow", {63'd0, sb_underflow}, 64'd0);

    // 0x10000 commits wrap the retire counter back to zero
    issue_valid = 1'b1; issue_dest = 4'd1;
    commit(8'h40, 4'd1, 64'h1, 64'h0);
    for (int i = 0; i < 65536; i++) begin
      mem_alu_result = 64'(i);
      cycle();
    end
    idle();
    #1;
    chk("t6_wrap", {48'd0, retire_count}, 64'd0);
    cycle();

    // Randomized traffic, biased toward a few registers to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      mem_valid       = $urandom_range(0, 1);
      mem_control_rod = 8'($urandom);
      mem_alu_result  = {$urandom, $urandom};
      mem_load_data   = {$urandom, $urandom};
      mem_dest        = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      issue_valid     = $urandom_range(0, 1);
      issue_dest      = 4'($urandom_range(0, 3));
      query_addr1     = 4'($urandom_range(0, 3));
      query_addr2     = 4'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
